change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Pays out change owed by the vending controller as discrete coins over a valid/ack handshake to the coin hopper.
- Takes a change amount and pays it out greedily, largest denomination first: 5, then 2, then 1.
- Tracks per-denomination coin stock, which the service port can refill.
- Reports completion, or failure with the unpaid remainder.

Parameters:
- W, 5, width of amount and remaining.
- CW, 4, width of each coin stock counter.
- INIT_STOCK, 4, reset value of every stock counter (must be ≤ 2^CW-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- start  in  1  request payout of amount; sampled only in IDLE
- amount  in  W  change to pay; captured on accepted start
- coin_valid  out  1  hopper request active
- coin_sel  out  2  coin to eject: 0=1-unit, 1=2-unit, 2=5-unit (3 never driven)
- coin_ack  in  1  hopper accepts the coin; completes the transfer when high with coin_valid
- refill  in  1  add refill_cnt coins to stock[refill_sel]
- refill_sel  in  2  0=1-unit, 1=2-unit, 2=5-unit; 3 is ignored
- refill_cnt  in  CW  coins added
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: remaining reached 0
- fail  out  1  one-cycle pulse: stock is exhausted with remaining > 0
- remaining  out  W  unpaid balance
- stock_lo, stock_mid, stock_hi  out  CW each  current coin stock

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset values: state=IDLE; coin_valid, coin_sel, busy, done, fail and remaining all 0; all stocks = INIT_STOCK.
  - Reset mid-payout aborts immediately: coin_valid drops asynchronously.
  - Coins already acked are not restored to stock.
- FSM states: IDLE, CHECK, ISSUE, DONE, FAIL.
- IDLE:
  - start=1 → remaining<=amount, go to CHECK next edge.
  - start is ignored in all other states.
- CHECK (one cycle, no coin_valid):
  - Pick the largest denomination d with d ≤ remaining and stock[d] > 0.
  - remaining==0 → DONE.
  - A denomination is found → latch coin_sel, go to ISSUE.
  - None found → FAIL.
- ISSUE:
  - coin_valid=1, coin_sel stable until ack.
  - On coin_valid&coin_ack at an edge: remaining -= d, stock[coin_sel] -= 1, go to CHECK.
  - coin_valid is low in the CHECK cycle, so at most one coin is requested per two cycles.
- DONE and FAIL: assert done or fail for exactly one cycle, then IDLE. remaining holds its final value until the next accepted start.
- Greedy is normative, even where an exact non-greedy payout exists.
  - Example: amount 6 with stock_lo=0, stocks hi≥1 and mid≥3.
  - Pays 5, leaves remaining=1, then FAIL.
- Refill:
  - Accepted in any state, including mid-payout.
  - stock += refill_cnt, saturating at 2^CW-1.
  - Refill and a coin decrement on the same denomination in the same cycle: result = sat(stock + refill_cnt − 1).
  - Refill takes effect for the next CHECK.
- Arithmetic: remaining never underflows, because d ≤ remaining is guaranteed by CHECK.
- Latency: start → first coin_valid is 2 cycles. amount=0 → done pulse asserted 2 cycles after start, with no coin_valid.

Test Plan:
1. Reset, stocks 4/4/4. start with amount=8, coin_ack tied high.
   - coin_sel sequence 2,1,0.
   - done pulse; remaining=0; stocks hi=3, mid=3, lo=3.
2. start with amount=0 → done pulse 2 cycles after start; coin_valid never high; busy high for exactly 2 cycles.
3. Fresh reset, stocks 4/4/4. amount=22 → four 5s then one 2 → done, stock_hi=0, stock_mid=3. Then amount=6 → 2,2,2 → done, stock_mid=0.
4. Fresh reset, INIT_STOCK=1. amount=9 → 5,2,1 dispensed → fail pulse, remaining=1, all stocks 0.
5. Hold coin_ack low for 5 cycles in ISSUE → coin_valid, coin_sel, remaining and stock stay stable. Start pulsed during this → ignored.
6. Saturation and overlap:
   - stock_mid=3, then refill_sel=1, refill_cnt=15 → stock_mid=15 (saturated).
   - stock_mid=3, refill_cnt=2 in the same cycle as a MID coin ack → stock_mid=4.
   - Assert rst low during ISSUE → coin_valid=0 immediately, stocks return to INIT_STOCK.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: pays a change amount as 5/2/1-unit coins over a
// valid/ack handshake to the hopper, tracking and refilling per-coin stock.
module change_dispenser #(
  parameter int W          = 5,
  parameter int CW         = 4,
  parameter int INIT_STOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  amount,
  output logic          coin_valid,
  output logic [1:0]    coin_sel,
  input  logic          coin_ack,
  input  logic          refill,
  input  logic [1:0]    refill_sel,
  input  logic [CW-1:0] refill_cnt,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [W-1:0]  remaining,
  output logic [CW-1:0] stock_lo,
  output logic [CW-1:0] stock_mid,
  output logic [CW-1:0] stock_hi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam logic [1:0]    SEL_LO    = 2'd0;
  localparam logic [1:0]    SEL_MID   = 2'd1;
  localparam logic [1:0]    SEL_HI    = 2'd2;
  localparam logic [W-1:0]  VAL_LO    = W'(1);
  localparam logic [W-1:0]  VAL_MID   = W'(2);
  localparam logic [W-1:0]  VAL_HI    = W'(5);
  localparam logic [CW:0]   STOCK_MAX = {1'b0, {CW{1'b1}}};
  localparam logic [CW-1:0] STOCK_RST = CW'(INIT_STOCK);

  state_t        state_q, state_d;
  logic [W-1:0]  remaining_q, remaining_d;
  logic [1:0]    coin_sel_q, coin_sel_d;
  logic          coin_valid_q, coin_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] stock_q [3];
  logic [CW-1:0] stock_d [3];
  logic          coin_taken;

  function automatic logic [W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_HI:  return VAL_HI;
      SEL_MID: return VAL_MID;
      default: return VAL_LO;
    endcase
  endfunction

  // A same-cycle refill and payout decrement combine before saturation; the
  // decrement only happens on a non-empty counter, so the sum never underflows.
  function automatic logic [CW-1:0] next_stock(input logic [CW-1:0] cur,
                                               input logic          add_en,
                                               input logic [CW-1:0] add,
                                               input logic          dec);
    logic [CW:0] sum;
    sum = {1'b0, cur} + (add_en ? {1'b0, add} : {(CW+1){1'b0}})
          - {{CW{1'b0}}, dec};
    if (sum > STOCK_MAX) return {CW{1'b1}};
    return sum[CW-1:0];
  endfunction

  assign coin_taken = (state_q == ISSUE) && coin_valid_q && coin_ack;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = amount;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (remaining_q >= VAL_HI && stock_q[2] != '0) begin
          coin_sel_d = SEL_HI;
          state_d    = ISSUE;
        end else if (remaining_q >= VAL_MID && stock_q[1] != '0) begin
          coin_sel_d = SEL_MID;
          state_d    = ISSUE;
        end else if (stock_q[0] != '0) begin
          coin_sel_d = SEL_LO;
          state_d    = ISSUE;
        end else begin
          state_d = FAIL;
        end
      end
      ISSUE: begin
        if (coin_taken) begin
          remaining_d = remaining_q - coin_value(coin_sel_q);
          state_d     = CHECK;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 3; i++) begin
      stock_d[i] = next_stock(stock_q[i],
                              refill && (refill_sel == 2'(i)),
                              refill_cnt,
                              coin_taken && (coin_sel_q == 2'(i)));
    end

    // Outputs are registered straight from the next state so they line up with it.
    coin_valid_d = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    fail_d       = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      coin_sel_q   <= SEL_LO;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      for (int i = 0; i < 3; i++) stock_q[i] <= STOCK_RST;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_sel_q   <= coin_sel_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      for (int i = 0; i < 3; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_sel   = coin_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign remaining  = remaining_q;
  assign stock_lo   = stock_q[0];
  assign stock_mid  = stock_q[1];
  assign stock_hi   = stock_q[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; a second instance with
// a stock of one coin per denomination exercises the exhaustion path.
module tb_change_dispenser;
  localparam int W  = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  amount;
  logic          coin_ack;
  logic          refill;
  logic [1:0]    refill_sel;
  logic [CW-1:0] refill_cnt;

  logic          coin_valid, busy, done, fail;
  logic [1:0]    coin_sel;
  logic [W-1:0]  remaining;
  logic [CW-1:0] stock_lo, stock_mid, stock_hi;

  logic          coin_valid1, busy1, done1, fail1;
  logic [1:0]    coin_sel1;
  logic [W-1:0]  remaining1;
  logic [CW-1:0] stock_lo1, stock_mid1, stock_hi1;

  int checks   = 0;
  int failures = 0;
  int seq_code;
  int n_coins;
  bit got_done, got_fail;

  always #5 clk = ~clk;

  change_dispenser #(.W(W), .CW(CW), .INIT_STOCK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .busy(busy), .done(done), .fail(fail), .remaining(remaining),
    .stock_lo(stock_lo), .stock_mid(stock_mid), .stock_hi(stock_hi)
  );

  change_dispenser #(.W(W), .CW(CW), .INIT_STOCK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .coin_valid(coin_valid1), .coin_sel(coin_sel1), .coin_ack(coin_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .busy(busy1), .done(done1), .fail(fail1), .remaining(remaining1),
    .stock_lo(stock_lo1), .stock_mid(stock_mid1), .stock_hi(stock_hi1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    start      = 1'b0;
    amount     = '0;
    coin_ack   = 1'b0;
    refill     = 1'b0;
    refill_sel = 2'd0;
    refill_cnt = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  // Coins are encoded as decimal digits (sel+1) so a whole sequence compares as one number.
  task automatic do_payout(input logic [W-1:0] amt, input bit watch1);
    seq_code = 0;
    n_coins  = 0;
    got_done = 1'b0;
    got_fail = 1'b0;
    coin_ack = 1'b1;
    start    = 1'b1;
    amount   = amt;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !got_done && !got_fail; i++) begin
      if (watch1) begin
        if (coin_valid1) begin seq_code = seq_code * 10 + int'(coin_sel1) + 1; n_coins++; end
        got_done = done1;
        got_fail = fail1;
      end else begin
        if (coin_valid) begin seq_code = seq_code * 10 + int'(coin_sel) + 1; n_coins++; end
        got_done = done;
        got_fail = fail;
      end
      if (!got_done && !got_fail) tick();
    end
    checks++;
    if (!got_done && !got_fail) begin
      failures++;
      $display("[TB] FAIL payout_timeout amount=%0d got no done/fail, required one", amt);
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 ||
        remaining !== 5'd0 || coin_sel !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got cv=%b busy=%b done=%b fail=%b rem=%0d sel=%0d, required all 0",
               coin_valid, busy, done, fail, remaining, coin_sel);
    end
    checks++;
    if (stock_lo !== 4'd4 || stock_mid !== 4'd4 || stock_hi !== 4'd4) begin
      failures++;
      $display("[TB] FAIL reset_stock got %0d/%0d/%0d, required 4/4/4", stock_lo, stock_mid, stock_hi);
    end
  endtask

  task automatic test_basic_payout();
    do_payout(5'd8, 1'b0);
    checks++;
    if (seq_code !== 321 || n_coins !== 3 || !got_done) begin
      failures++;
      $display("[TB] FAIL pay8_sequence got code=%0d n=%0d done=%b, required code=321 n=3 done=1",
               seq_code, n_coins, got_done);
    end
    checks++;
    if (remaining !== 5'd0 || stock_hi !== 4'd3 || stock_mid !== 4'd3 || stock_lo !== 4'd3) begin
      failures++;
      $display("[TB] FAIL pay8_state got rem=%0d stocks hi/mid/lo=%0d/%0d/%0d, required 0 and 3/3/3",
               remaining, stock_hi, stock_mid, stock_lo);
    end
  endtask

  task automatic test_zero_amount();
    coin_ack = 1'b0;
    start    = 1'b1;
    amount   = 5'd0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || coin_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_cycle1 got busy=%b done=%b cv=%b, required 1/0/0", busy, done, coin_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || coin_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_cycle2 got busy=%b done=%b cv=%b, required 1/1/0", busy, done, coin_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || coin_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_cycle3 got busy=%b done=%b cv=%b, required 0/0/0", busy, done, coin_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_payout(5'd22, 1'b0);
    checks++;
    if (seq_code !== 33332 || !got_done || stock_hi !== 4'd0 || stock_mid !== 4'd3) begin
      failures++;
      $display("[TB] FAIL pay22 got code=%0d done=%b hi=%0d mid=%0d, required 33332/1/0/3",
               seq_code, got_done, stock_hi, stock_mid);
    end
    do_payout(5'd6, 1'b0);
    checks++;
    if (seq_code !== 222 || !got_done || stock_mid !== 4'd0 || stock_lo !== 4'd4 || remaining !== 5'd0) begin
      failures++;
      $display("[TB] FAIL pay6 got code=%0d done=%b mid=%0d lo=%0d rem=%0d, required 222/1/0/4/0",
               seq_code, got_done, stock_mid, stock_lo, remaining);
    end
  endtask

  task automatic test_exhaustion();
    apply_reset();
    do_payout(5'd9, 1'b1);
    checks++;
    if (seq_code !== 321 || !got_fail || got_done) begin
      failures++;
      $display("[TB] FAIL pay9_fail got code=%0d fail=%b done=%b, required 321/1/0", seq_code, got_fail, got_done);
    end
    checks++;
    if (remaining1 !== 5'd1 || stock_lo1 !== 4'd0 || stock_mid1 !== 4'd0 || stock_hi1 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL pay9_state got rem=%0d stocks=%0d/%0d/%0d, required 1 and 0/0/0",
               remaining1, stock_lo1, stock_mid1, stock_hi1);
    end
  endtask

  task automatic test_ack_stall();
    apply_reset();
    coin_ack = 1'b0;
    start    = 1'b1;
    amount   = 5'd8;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (coin_valid !== 1'b1 || coin_sel !== 2'd2 || remaining !== 5'd8 || stock_hi !== 4'd4 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] got cv=%b sel=%0d rem=%0d hi=%0d, required 1/2/8/4", i,
                 coin_valid, coin_sel, remaining, stock_hi);
      end
      start  = (i == 2);
      amount = 5'd3;
      tick();
    end
    start    = 1'b0;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    checks++;
    if (coin_valid !== 1'b0 || remaining !== 5'd3 || stock_hi !== 4'd3) begin
      failures++;
      $display("[TB] FAIL stall_release got cv=%b rem=%0d hi=%0d, required 0/3/3", coin_valid, remaining, stock_hi);
    end
    tick();
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 2'd1) begin
      failures++;
      $display("[TB] FAIL stall_next got cv=%b sel=%0d, required 1/1", coin_valid, coin_sel);
    end
    coin_ack = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      got_done = done;
    end
    checks++;
    if (!got_done || remaining !== 5'd0) begin
      failures++;
      $display("[TB] FAIL stall_finish got done=%b rem=%0d, required 1/0", got_done, remaining);
    end
    coin_ack = 1'b0;
    tick();
  endtask

  task automatic test_refill_overlap();
    apply_reset();
    do_payout(5'd2, 1'b0);
    refill     = 1'b1;
    refill_sel = 2'd1;
    refill_cnt = 4'd15;
    tick();
    refill = 1'b0;
    checks++;
    if (stock_mid !== 4'd15) begin
      failures++;
      $display("[TB] FAIL refill_saturate got mid=%0d, required 15", stock_mid);
    end

    apply_reset();
    do_payout(5'd2, 1'b0);
    coin_ack = 1'b0;
    start    = 1'b1;
    amount   = 5'd2;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 2'd1 || stock_mid !== 4'd3) begin
      failures++;
      $display("[TB] FAIL overlap_setup got cv=%b sel=%0d mid=%0d, required 1/1/3", coin_valid, coin_sel, stock_mid);
    end
    coin_ack   = 1'b1;
    refill     = 1'b1;
    refill_sel = 2'd1;
    refill_cnt = 4'd2;
    tick();
    coin_ack = 1'b0;
    refill   = 1'b0;
    checks++;
    if (stock_mid !== 4'd4 || remaining !== 5'd0) begin
      failures++;
      $display("[TB] FAIL overlap_result got mid=%0d rem=%0d, required 4/0", stock_mid, remaining);
    end
    tick();
    tick();

    start  = 1'b1;
    amount = 5'd8;
    tick();
    start = 1'b0;
    tick();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 2'd1 || stock_hi !== 4'd3) begin
      failures++;
      $display("[TB] FAIL abort_setup got cv=%b sel=%0d hi=%0d, required 1/1/3", coin_valid, coin_sel, stock_hi);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || remaining !== 5'd0 || stock_hi !== 4'd4) begin
      failures++;
      $display("[TB] FAIL reset_abort got cv=%b busy=%b rem=%0d hi=%0d, required 0/0/0/4",
               coin_valid, busy, remaining, stock_hi);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_payout();
    test_zero_amount();
    test_back_to_back();
    test_exhaustion();
    test_ack_stall();
    test_refill_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
